// File: rtl/uart_rx_stream_param.sv
// uart_rx_stream_param
// Oversampling UART receiver with a configurable frame format (5..9 data
// bits, none/odd/even parity, 1 or 2 stop bits). Each bit is sampled three
// times around its centre and decided by a 2-of-3 majority vote. Decoded
// words leave on a one-entry valid/ready stream together with their parity
// and framing error flags. A frame that completes while the previous word is
// still held is dropped and reported on o_overrun. A break (all-zero frame
// with a zero first stop bit) is reported on o_break and is not delivered.
//
// Ports
//   i_clk         single clock
//   i_rst_n       synchronous active-low reset
//   i_uart_rx     asynchronous serial input, idle high
//   o_rx_data     received word, LSB = first data bit
//   o_rx_valid    o_rx_data/o_parity_err/o_frame_err hold a word
//   i_rx_ready    consumer accepts the held word
//   o_parity_err  parity mismatch for the held word
//   o_frame_err   a stop bit of the held word sampled 0
//   o_overrun     one-cycle pulse, a completed frame was dropped
//   o_break       one-cycle pulse, break detected
//   o_busy        receiver is inside a frame or waiting for break release
module uart_rx_stream_param #(
    parameter int P_CLK_FREQ   = 50_000_000,
    parameter int P_BAUD       = 115200,
    parameter int P_OVERSAMPLE = 16,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_PARITY     = 0,
    parameter int P_STOP_BITS  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_uart_rx,
    output logic [P_DATA_WIDTH-1:0] o_rx_data,
    output logic                    o_rx_valid,
    input  logic                    i_rx_ready,
    output logic                    o_parity_err,
    output logic                    o_frame_err,
    output logic                    o_overrun,
    output logic                    o_break,
    output logic                    o_busy
);

    localparam int DIV_RAW = P_CLK_FREQ / (P_BAUD * P_OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(P_OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  SMP_A     = OS_W'(P_OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMP_B     = OS_W'(P_OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SMP_C     = OS_W'(P_OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(P_OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(P_DATA_WIDTH - 1);
    localparam logic [3:0]       STOP_LAST = 4'(P_STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP       = 3'd4,
        S_BREAK_WAIT = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]         os_cnt_q, os_cnt_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [1:0]              smp_q, smp_d;
    logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                    par_err_q, par_err_d;
    logic                    frm_err_q, frm_err_d;
    logic                    brk_ok_q, brk_ok_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    pe_q, pe_d;
    logic                    fe_q, fe_d;
    logic                    ovr_q, ovr_d;
    logic                    brk_q, brk_d;
    logic                    busy_q, busy_d;

    logic fall_s, tick_s, vote_s, decide_s, bit_end_s, done_s, brk_s;

    // Falling edge on the synchronised line; tick gating; majority of the three samples.
    assign fall_s    = sync3_q & ~sync2_q;
    assign tick_s    = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);
    assign vote_s    = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
    assign decide_s  = tick_s && (os_cnt_q == SMP_C);
    assign bit_end_s = tick_s && (os_cnt_q == OS_LAST);

    assign o_rx_data    = data_q;
    assign o_rx_valid   = valid_q;
    assign o_parity_err = pe_q;
    assign o_frame_err  = fe_q;
    assign o_overrun    = ovr_q;
    assign o_break      = brk_q;
    assign o_busy       = busy_q;

    // Next-state logic: synchroniser, bit timing, frame FSM and output register.
    always_comb begin
        sync1_d   = i_uart_rx;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        smp_d     = smp_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        brk_ok_d  = brk_ok_q;
        data_d    = data_q;
        valid_d   = valid_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        ovr_d     = 1'b0;
        brk_d     = 1'b0;
        done_s    = 1'b0;
        brk_s     = 1'b0;

        // Counters sit at zero in IDLE so a new start edge always begins a fresh bit.
        if (state_q == S_IDLE) begin
            div_cnt_d = '0;
            os_cnt_d  = '0;
        end else if (tick_s) begin
            div_cnt_d = '0;
            os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // The first two samples are stored; the third is the live line at the decision tick.
        if (tick_s && (os_cnt_q == SMP_A)) begin
            smp_d[0] = sync2_q;
        end else if (tick_s && (os_cnt_q == SMP_B)) begin
            smp_d[1] = sync2_q;
        end else begin
            smp_d = smp_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fall_s) begin
                    state_d   = S_START;
                    bit_cnt_d = 4'd0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                    brk_ok_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (decide_s && vote_s) begin
                    state_d = S_IDLE;
                end else if (bit_end_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 4'd0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (decide_s) begin
                    shift_d = {vote_s, shift_q[P_DATA_WIDTH-1:1]};
                end else if (bit_end_s) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = 4'd0;
                        state_d   = (P_PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (decide_s) begin
                    // Odd: data ^ parity must be 1; even: it must be 0.
                    par_err_d = (P_PARITY == 1) ? ~(^shift_q ^ vote_s) : (^shift_q ^ vote_s);
                    brk_ok_d  = brk_ok_q & ~vote_s;
                end else if (bit_end_s) begin
                    state_d   = S_STOP;
                    bit_cnt_d = 4'd0;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (decide_s) begin
                    frm_err_d = frm_err_q | ~vote_s;
                    brk_ok_d  = ((bit_cnt_q == 4'd0) && vote_s) ? 1'b0 : brk_ok_q;
                    // Completing at the decision point leaves slack for a back-to-back start bit.
                    if (bit_cnt_q == STOP_LAST) begin
                        done_s  = 1'b1;
                        brk_s   = (shift_q == '0) && brk_ok_q && !((bit_cnt_q == 4'd0) && vote_s);
                        state_d = brk_s ? S_BREAK_WAIT : S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end else if (bit_end_s) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK_WAIT: begin
                if (sync2_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // One-entry output register; a completion may reuse the slot in the handshake cycle.
        if (done_s && !brk_s) begin
            if (!valid_q || i_rx_ready) begin
                data_d  = shift_q;
                pe_d    = par_err_q;
                fe_d    = frm_err_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            brk_d = done_s & brk_s;
            if (valid_q && i_rx_ready) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            sync3_q   <= 1'b1;
            div_cnt_q <= '0;
            os_cnt_q  <= '0;
            bit_cnt_q <= 4'd0;
            smp_q     <= 2'b11;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            brk_ok_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            brk_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            div_cnt_q <= div_cnt_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            smp_q     <= smp_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            brk_ok_q  <= brk_ok_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            brk_q     <= brk_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_stream_param.sv
// Bench for uart_rx_stream_param: three receivers (8N1, 8E1, 9N2) on a
// 16 MHz clock at 1 Mbaud, 16x oversampling (one tick per clock).
module tb_uart_rx_stream_param;

    localparam int CLK = 16_000_000;
    localparam int BAUD = 1_000_000;
    localparam int OS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] rx_v;
    logic [2:0] rdy_v;
    wire  [7:0] d0, d1;
    wire  [8:0] d2;
    wire  [2:0] v, pe, fe, ov, bk, by;

    int checks = 0;
    int errors = 0;
    int ov_cnt [3];
    int bk_cnt [3];
    logic [12:0] acc [$];   // accepted words {inst, fe, pe, data}

    uart_rx_stream_param #(.P_CLK_FREQ(CLK), .P_BAUD(BAUD), .P_OVERSAMPLE(OS),
        .P_DATA_WIDTH(8), .P_PARITY(0), .P_STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_v[0]), .o_rx_data(d0),
        .o_rx_valid(v[0]), .i_rx_ready(rdy_v[0]), .o_parity_err(pe[0]),
        .o_frame_err(fe[0]), .o_overrun(ov[0]), .o_break(bk[0]), .o_busy(by[0]));

    uart_rx_stream_param #(.P_CLK_FREQ(CLK), .P_BAUD(BAUD), .P_OVERSAMPLE(OS),
        .P_DATA_WIDTH(8), .P_PARITY(2), .P_STOP_BITS(1)) u_8e1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_v[1]), .o_rx_data(d1),
        .o_rx_valid(v[1]), .i_rx_ready(rdy_v[1]), .o_parity_err(pe[1]),
        .o_frame_err(fe[1]), .o_overrun(ov[1]), .o_break(bk[1]), .o_busy(by[1]));

    uart_rx_stream_param #(.P_CLK_FREQ(CLK), .P_BAUD(BAUD), .P_OVERSAMPLE(OS),
        .P_DATA_WIDTH(9), .P_PARITY(0), .P_STOP_BITS(2)) u_9n2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_v[2]), .o_rx_data(d2),
        .o_rx_valid(v[2]), .i_rx_ready(rdy_v[2]), .o_parity_err(pe[2]),
        .o_frame_err(fe[2]), .o_overrun(ov[2]), .o_break(bk[2]), .o_busy(by[2]));

    function automatic logic [8:0] dat(input int i);
        if (i == 0) return {1'b0, d0};
        else if (i == 1) return {1'b0, d1};
        else return d2;
    endfunction

    // Observer: records accepted words and counts overrun/break pulses.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (v[i] && rdy_v[i]) acc.push_back({2'(i), fe[i], pe[i], dat(i)});
            if (ov[i]) ov_cnt[i]++;
            if (bk[i]) bk_cnt[i]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int fmt_dw(input int inst);
        return (inst == 2) ? 9 : 8;
    endfunction

    // Reference model: outcome of one frame from the line-level rules.
    task automatic model(input int inst, input logic [8:0] data, input logic pbit,
                         input logic s0, input logic s1, output logic brk, output logic [12:0] e);
        int par, nst, ones;
        logic pe_e, fe_e;
        logic [8:0] d;
        par = (inst == 1) ? 2 : 0;
        nst = (inst == 2) ? 2 : 1;
        d = data & ((9'h001 << fmt_dw(inst)) - 9'h001);
        ones = $countones(d);
        if (par == 0) pe_e = 1'b0;
        else pe_e = (((ones + int'(pbit)) % 2) != ((par == 1) ? 1 : 0));
        fe_e = !s0 || (nst == 2 && !s1);
        brk = (d == 9'h000) && (par == 0 || !pbit) && !s0;
        e = {inst[1:0], fe_e, pe_e, d};
    endtask

    function automatic logic good_par(input logic [8:0] data);
        return ^data[7:0];   // even parity for the 8E1 receiver
    endfunction

    // Drive one frame on rx_v[inst]; optionally raise ready for exactly one clock index.
    task automatic send(input int inst, input logic [8:0] data, input logic pbit,
                        input logic s0, input logic s1, input int ready_off, input int idle);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < fmt_dw(inst); i++) bits.push_back(data[i]);
        if (inst == 1) bits.push_back(pbit);
        bits.push_back(s0);
        if (inst == 2) bits.push_back(s1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < OS; c++) begin
                rx_v[inst] = bits[b];
                if (ready_off >= 0) rdy_v[inst] = ((b * OS + c) == ready_off);
                @(negedge clk);
            end
        end
        if (ready_off >= 0) rdy_v[inst] = 1'b0;
        rx_v[inst] = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    // One frame with ready held high, compared against the model.
    task automatic run_frame(input int inst, input logic [8:0] data, input logic pbit,
                             input logic s0, input logic s1, input int idle);
        int bk0;
        logic brk;
        logic [12:0] e, got;
        bk0 = bk_cnt[inst];
        acc.delete();
        rdy_v[inst] = 1'b1;
        send(inst, data, pbit, s0, s1, -1, idle);
        model(inst, data, pbit, s0, s1, brk, e);
        if (brk) begin
            chk("break_pulse", bk_cnt[inst] - bk0, 1);
            chk("break_no_word", acc.size(), 0);
        end else begin
            chk("word_count", acc.size(), 1);
            got = (acc.size() > 0) ? acc.pop_front() : 13'bx;
            chk("word", got, e);
            chk("no_break", bk_cnt[inst] - bk0, 0);
        end
        chk("idle_after", by[inst], 1'b0);
        rdy_v[inst] = 1'b0;
    endtask

    task automatic chk_reset(input int i);
        chk("reset_outputs", {v[i], pe[i], fe[i], ov[i], bk[i], by[i], dat(i)}, 0);
    endtask

    initial begin
        int ov0, bk0;
        logic [12:0] got;
        rst_n = 1'b0;
        rx_v  = 3'b111;
        rdy_v = 3'b000;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset(i);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 word
        run_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1, 8);
        // even parity: wrong then right parity bit
        run_frame(1, 9'h03C, 1'b1, 1'b1, 1'b1, 8);
        run_frame(1, 9'h03C, 1'b0, 1'b1, 1'b1, 8);
        // framing error
        run_frame(0, 9'h055, 1'b0, 1'b0, 1'b1, 8);
        // break: line low for 20 bit times
        bk0 = bk_cnt[0];
        acc.delete();
        rdy_v[0] = 1'b1;
        rx_v[0] = 1'b0;
        repeat (20 * OS) @(negedge clk);
        rx_v[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("long_break_pulses", bk_cnt[0] - bk0, 1);
        chk("long_break_no_word", acc.size(), 0);
        chk("long_break_idle", by[0], 1'b0);
        rdy_v[0] = 1'b0;
        run_frame(0, 9'h012, 1'b0, 1'b1, 1'b1, 8);

        // glitch reject
        acc.delete();
        rdy_v[0] = 1'b1;
        rx_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx_v[0] = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_busy_drop", by[0], 1'b0);
        repeat (16) @(negedge clk);
        chk("glitch_no_word", acc.size(), 0);
        rdy_v[0] = 1'b0;
        run_frame(0, 9'h081, 1'b0, 1'b1, 1'b1, 8);

        // overrun: two back-to-back frames with ready low
        acc.delete();
        ov0 = ov_cnt[0];
        send(0, 9'h011, 1'b0, 1'b1, 1'b1, -1, 0);
        send(0, 9'h022, 1'b0, 1'b1, 1'b1, -1, 8);
        chk("ovr_valid", v[0], 1'b1);
        chk("ovr_data_kept", d0, 8'h11);
        chk("ovr_pulses", ov_cnt[0] - ov0, 1);
        rdy_v[0] = 1'b1;
        @(negedge clk);
        rdy_v[0] = 1'b0;
        @(negedge clk);
        chk("ovr_release_count", acc.size(), 1);
        got = (acc.size() > 0) ? acc.pop_front() : 13'bx;
        chk("ovr_release_word", got, 13'h0011);
        chk("ovr_release_valid", v[0], 1'b0);

        // ready exactly on the completion cycle of the second frame
        acc.delete();
        ov0 = ov_cnt[0];
        send(0, 9'h011, 1'b0, 1'b1, 1'b1, -1, 0);
        send(0, 9'h022, 1'b0, 1'b1, 1'b1, OS / 2 + 4 + OS * 9, 8);
        chk("sim_hs_valid", v[0], 1'b1);
        chk("sim_hs_data", d0, 8'h22);
        chk("sim_hs_no_ovr", ov_cnt[0] - ov0, 0);
        chk("sim_hs_count", acc.size(), 1);
        got = (acc.size() > 0) ? acc.pop_front() : 13'bx;
        chk("sim_hs_old_word", got, 13'h0011);
        rdy_v[0] = 1'b1;
        @(negedge clk);
        rdy_v[0] = 1'b0;
        @(negedge clk);
        got = (acc.size() > 0) ? acc.pop_front() : 13'bx;
        chk("sim_hs_new_word", got, 13'h0022);

        // reset during DATA with a word held
        send(0, 9'h05A, 1'b0, 1'b1, 1'b1, -1, 4);
        chk("pre_reset_valid", v[0], 1'b1);
        rx_v[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("pre_reset_busy", by[0], 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset(i);
        rst_n = 1'b1;
        rx_v[0] = 1'b1;
        repeat (20) @(negedge clk);
        run_frame(0, 9'h03A, 1'b0, 1'b1, 1'b1, 8);

        // 9 data bits, 2 stop bits
        run_frame(2, 9'h1A5, 1'b0, 1'b1, 1'b1, 8);
        run_frame(2, 9'h1A5, 1'b0, 1'b1, 1'b0, 8);

        // randomized frames across all three formats
        for (int n = 0; n < 24; n++) begin
            int inst;
            logic [8:0] dd;
            logic pb, a, b;
            inst = $urandom_range(0, 2);
            dd = 9'($urandom);
            if ($urandom_range(0, 7) == 0) dd = 9'h000;
            pb = good_par(dd) ^ ($urandom_range(0, 4) == 0);
            a  = ($urandom_range(0, 5) != 0);
            b  = ($urandom_range(0, 5) != 0);
            run_frame(inst, dd, pb, a, b, $urandom_range(4, 24));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
